// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main controller: states, opcodes,
// datapath select codes and the ALU decode classes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRLINK = 4'd12,
    UPPER    = 4'd13,
    TRAP     = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    ACLS_ADD    = 2'd0,
    ACLS_BRANCH = 2'd1,
    ACLS_RTYPE  = 2'd2,
    ACLS_ITYPE  = 2'd3
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from the controller's operation class
// and the instruction funct fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ACLS_ADD: alu_control = ALU_ADD;
      ACLS_BRANCH: begin
        // beq/bne compare by subtraction; signed and unsigned orderings use slt/sltu
        case (funct3)
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_SUB;
        endcase
      end
      ACLS_RTYPE, ACLS_ITYPE: begin
        case (funct3)
          3'b000: alu_control = (funct7b5 && alu_class == ACLS_RTYPE) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style main control FSM for the multicycle RV32I datapath, with a
// mem_req/mem_ready handshake, optional memory timeout and a terminal trap state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  // mem_req is valid from entry into a memory state until the cycle mem_ready
  // is sampled high; the request and its address are held stable meanwhile.
  state_t          state_q, state_d;
  logic [1:0]      cause_q, cause_d;
  logic [TO_W-1:0] to_cnt;
  alu_class_t      alu_class;
  logic            req_raw, wr_raw, irw_raw, pcw_raw, rw_raw;
  logic            timeout_hit;
  logic            br_illegal, br_taken;

  assign timeout_hit = (MEM_TIMEOUT != 0) && req_raw && !mem_ready &&
                       (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  assign br_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);

  always_comb begin
    case (funct3)
      3'b000:                 br_taken = Zero;
      3'b001, 3'b100, 3'b110: br_taken = !Zero;
      3'b101, 3'b111:         br_taken = Zero;
      default:                br_taken = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cause_q <= CAUSE_NONE;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d != state_q || mem_ready)
        to_cnt <= '0;
      else if (req_raw && !mem_ready)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    req_raw   = 1'b0;
    wr_raw    = 1'b0;
    irw_raw   = 1'b0;
    pcw_raw   = 1'b0;
    rw_raw    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    alu_class = ACLS_ADD;
    case (state_q)
      FETCH: begin
        req_raw   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          irw_raw = 1'b1;
          pcw_raw = 1'b1;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI, OP_AUIPC:  state_d = UPPER;
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD, MEMWRITE: begin
        req_raw = 1'b1;
        wr_raw  = (state_q == MEMWRITE);
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_d = (state_q == MEMWRITE) ? FETCH : MEMWB;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        rw_raw    = 1'b1;
        state_d   = FETCH;
      end
      EXECR: begin
        ALUSrcA   = SRCA_RS1;
        alu_class = ACLS_RTYPE;
        state_d   = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        alu_class = ACLS_ITYPE;
        state_d   = ALUWB;
      end
      ALUWB: begin
        rw_raw  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        alu_class = ACLS_BRANCH;
        if (br_illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          pcw_raw = br_taken;
          state_d = FETCH;
        end
      end
      JAL: begin
        // ALUOut already holds the target from DECODE; this cycle forms the link
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw_raw = 1'b1;
        state_d = ALUWB;
      end
      JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pcw_raw   = 1'b1;
        state_d   = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        state_d = ALUWB;
      end
      UPPER: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        state_d = ALUWB;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Enables are gated by reset so an abandoned instruction can never write.
  assign mem_req    = req_raw & ~reset;
  assign MemWrite   = wr_raw  & ~reset;
  assign IRWrite    = irw_raw & ~reset;
  assign PCWrite    = pcw_raw & ~reset;
  assign RegWrite   = rw_raw  & ~reset;
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (timeout disabled and
// MEM_TIMEOUT=4) driven by the same stimulus, checked against hand values.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6,  S_EXECI = 4'd7,   S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10,    S_JALR = 4'd11,
                         S_JALRLINK = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd14;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, trap_cause;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state;

  logic       mem_req_t, MemWrite_t, AdrSrc_t, IRWrite_t, PCWrite_t, RegWrite_t, trap_t;
  logic [1:0] ResultSrc_t, ALUSrcA_t, ALUSrcB_t, trap_cause_t;
  logic [2:0] ImmSrc_t;
  logic [3:0] ALUControl_t, state_t_q;

  logic [4:0] en;
  assign en = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(0), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut_to (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req_t), .MemWrite(MemWrite_t),
    .AdrSrc(AdrSrc_t), .IRWrite(IRWrite_t), .PCWrite(PCWrite_t), .RegWrite(RegWrite_t),
    .ResultSrc(ResultSrc_t), .ALUSrcA(ALUSrcA_t), .ALUSrcB(ALUSrcB_t), .ImmSrc(ImmSrc_t),
    .ALUControl(ALUControl_t), .trap(trap_t), .trap_cause(trap_cause_t), .state(state_t_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_state", state, S_FETCH);
    check("rst_en", en, 5'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  // FETCH with zero-wait memory, then DECODE; leaves the FSM in the state after DECODE.
  task automatic fetch_decode(input string tag, input logic [2:0] exp_imm);
    mem_ready = 1'b1;
    #1;
    check({tag, "_fetch_state"}, state, S_FETCH);
    check({tag, "_fetch_en"}, en, 5'b10110);
    tick();
    check({tag, "_dec_state"}, state, S_DECODE);
    check({tag, "_dec_imm"}, ImmSrc, exp_imm);
    tick();
  endtask

  logic [6:0] ex_op  [8] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011,
                             7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};
  logic [2:0] ex_f3  [8] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b101, 3'b111, 3'b011, 3'b001};
  logic       ex_f7  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] ex_alu [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b1001,
                             4'b1000, 4'b0010, 4'b0110, 4'b0111};

  logic [2:0] br_f3  [7] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b101, 3'b111, 3'b110};
  logic       br_z   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       br_pc  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] br_alu [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0110, 4'b0110};

  initial begin
    reset = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    Zero = 1'b0;
    mem_ready = 1'b1;

    // reset held two cycles: enables forced low even though FETCH requests memory
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, S_FETCH);
    check("reset_trap", {trap, trap_cause}, 3'b000);
    check("reset_en", en, 5'b0);
    reset = 1'b0;

    // add x3,x1,x2
    #1;
    check("add_c1_state", state, S_FETCH);
    check("add_c1_rw", RegWrite, 1'b0);
    tick();
    check("add_c2_state", state, S_DECODE);
    check("add_c2_srca", ALUSrcA, 2'b01);
    check("add_c2_rw", RegWrite, 1'b0);
    tick();
    check("add_c3_state", state, S_EXECR);
    check("add_c3_alu", ALUControl, 4'b0000);
    check("add_c3_rw", RegWrite, 1'b0);
    tick();
    check("add_c4_state", state, S_ALUWB);
    check("add_c4_rw", RegWrite, 1'b1);
    tick();
    check("add_done_state", state, S_FETCH);

    // R/I-type ALU decode
    for (int i = 0; i < 8; i++) begin
      set_instr(ex_op[i], ex_f3[i], ex_f7[i]);
      fetch_decode($sformatf("ex%0d", i), 3'b010);
      check($sformatf("ex%0d_state", i), state, ex_op[i][4] && ex_op[i][5] ? S_EXECR : S_EXECI);
      check($sformatf("ex%0d_alu", i), ALUControl, ex_alu[i]);
      check($sformatf("ex%0d_srcb", i), ALUSrcB, ex_op[i][5] ? 2'b00 : 2'b01);
      tick();
      check($sformatf("ex%0d_wb", i), {state, RegWrite}, {S_ALUWB, 1'b1});
      tick();
    end

    // lw with three wait cycles; the timeout instance sees ready on its last allowed cycle
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_decode("lw", 3'b010);
    check("lw_adr_state", state, S_MEMADR);
    check("lw_adr_imm", ImmSrc, 3'b000);
    check("lw_adr_srca", ALUSrcA, 2'b10);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lw_wait%0d", i), {state, mem_req, AdrSrc, MemWrite}, {S_MEMREAD, 3'b110});
      check($sformatf("lw_wait%0d_to", i), state_t_q, S_MEMREAD);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_ready_state", {state, mem_req}, {S_MEMREAD, 1'b1});
    tick();
    check("lw_wb_state", state, S_MEMWB);
    check("lw_wb_ctl", {ResultSrc, RegWrite}, {2'b01, 1'b1});
    check("lw_wb_to_state", state_t_q, S_MEMWB);
    tick();
    check("lw_done", state, S_FETCH);

    // sw with zero wait
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_decode("sw", 3'b010);
    check("sw_adr_imm", ImmSrc, 3'b001);
    tick();
    check("sw_mw", {state, mem_req, MemWrite, AdrSrc}, {S_MEMWRITE, 3'b111});
    tick();
    check("sw_done", state, S_FETCH);

    // branches
    for (int i = 0; i < 7; i++) begin
      set_instr(7'b1100011, br_f3[i], 1'b0);
      Zero = br_z[i];
      fetch_decode($sformatf("br%0d", i), 3'b010);
      check($sformatf("br%0d_state", i), state, S_BRANCH);
      check($sformatf("br%0d_pcw", i), PCWrite, br_pc[i]);
      check($sformatf("br%0d_alu", i), ALUControl, br_alu[i]);
      tick();
      check($sformatf("br%0d_next", i), state, S_FETCH);
    end
    Zero = 1'b0;

    // jalr
    set_instr(7'b1100111, 3'b000, 1'b0);
    fetch_decode("jalr", 3'b010);
    check("jalr_state", state, S_JALR);
    check("jalr_ctl", {PCWrite, ResultSrc, ImmSrc, ALUSrcA}, {1'b1, 2'b10, 3'b000, 2'b10});
    tick();
    check("jalrlink_state", state, S_JALRLINK);
    check("jalrlink_src", {ALUSrcA, ALUSrcB, PCWrite}, {2'b01, 2'b10, 1'b0});
    tick();
    check("jalr_wb", {state, RegWrite}, {S_ALUWB, 1'b1});
    tick();

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_decode("jal", 3'b011);
    check("jal_ctl", {state, PCWrite, ResultSrc, ALUSrcA, ALUSrcB}, {S_JAL, 1'b1, 2'b00, 2'b01, 2'b10});
    tick();
    check("jal_wb", {state, RegWrite}, {S_ALUWB, 1'b1});
    tick();

    // lui and auipc
    set_instr(7'b0110111, 3'b000, 1'b0);
    fetch_decode("lui", 3'b010);
    check("lui_ctl", {state, ALUSrcA, ALUSrcB, ImmSrc}, {S_UPPER, 2'b11, 2'b01, 3'b100});
    tick();
    tick();
    set_instr(7'b0010111, 3'b000, 1'b0);
    fetch_decode("auipc", 3'b010);
    check("auipc_ctl", {state, ALUSrcA}, {S_UPPER, 2'b01});
    tick();
    check("auipc_wb", {state, RegWrite}, {S_ALUWB, 1'b1});
    tick();

    // illegal opcode: terminal trap
    set_instr(7'b0000000, 3'b000, 1'b0);
    fetch_decode("ill", 3'b010);
    check("ill_trap", {state, trap, trap_cause}, {S_TRAP, 1'b1, 2'b01});
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("ill_hold%0d", i), {state, en, trap}, {S_TRAP, 5'b0, 1'b1});
    end
    apply_reset();
    check("ill_cleared", {trap, trap_cause}, 3'b000);

    // illegal branch funct3
    set_instr(7'b1100011, 3'b010, 1'b0);
    Zero = 1'b0;
    fetch_decode("bill", 3'b010);
    check("bill_pcw", {state, PCWrite}, {S_BRANCH, 1'b0});
    tick();
    check("bill_trap", {state, trap_cause}, {S_TRAP, 2'b01});
    apply_reset();

    // memory timeout in FETCH: only the MEM_TIMEOUT=4 instance traps
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_wait%0d", i), {state_t_q, mem_req_t, IRWrite_t, PCWrite_t}, {S_FETCH, 3'b100});
      tick();
    end
    check("to_trap", {state_t_q, trap_t, trap_cause_t}, {S_TRAP, 1'b1, 2'b10});
    check("to_trap_en", {mem_req_t, MemWrite_t, RegWrite_t}, 3'b000);
    repeat (4) tick();
    check("noto_state", {state, trap, mem_req}, {S_FETCH, 1'b0, 1'b1});
    check("to_hold", {state_t_q, trap_cause_t}, {S_TRAP, 2'b10});
    apply_reset();
    check("to_cleared", {state_t_q, trap_t, trap_cause_t}, {S_FETCH, 3'b000});

    // reset asserted mid-MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_decode("rsw", 3'b010);
    tick();
    mem_ready = 1'b0;
    #1;
    check("rsw_mw", {state, MemWrite}, {S_MEMWRITE, 1'b1});
    tick();
    check("rsw_mw2", {state, MemWrite}, {S_MEMWRITE, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("rsw_rst", {state, MemWrite, mem_req}, {S_FETCH, 2'b00});
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rsw_after", {state, mem_req}, {S_FETCH, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
